// File: rtl/regfile_scoreboard_if.sv
// Register file access bundle: writeback, issue and read ports.
// master drives WEn/rd/rdv/iss_en/iss_rd/rs; slave returns rsv/rs_busy/busy_cnt.
interface regfile_scoreboard_if #(
  parameter int DATA_W  = 32,
  parameter int NUM_REG = 32,
  parameter int NUM_RD  = 2,
  parameter int IDX_W   = $clog2(NUM_REG)
);
  logic                     WEn;
  logic [IDX_W-1:0]         rd;
  logic [DATA_W-1:0]        rdv;
  logic                     iss_en;
  logic [IDX_W-1:0]         iss_rd;
  logic [NUM_RD*IDX_W-1:0]  rs;
  logic [NUM_RD*DATA_W-1:0] rsv;
  logic [NUM_RD-1:0]        rs_busy;
  logic [IDX_W:0]           busy_cnt;

  modport master (
    output WEn, rd, rdv, iss_en, iss_rd, rs,
    input  rsv, rs_busy, busy_cnt
  );

  modport slave (
    input  WEn, rd, rdv, iss_en, iss_rd, rs,
    output rsv, rs_busy, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Multi-read-port register file with pending-write scoreboard (x0 = 0).
// Ports: clk, rst (async high), bus (slave). Option: REGFILE_BYPASS_EN.
module regfile_scoreboard #(
  parameter int DATA_W  = 32,
  parameter int NUM_REG = 32,
  parameter int NUM_RD  = 2,
  parameter int IDX_W   = $clog2(NUM_REG)
) (
  input logic             clk,
  input logic             rst,
  regfile_scoreboard_if.slave bus
);

  logic [DATA_W-1:0]        regs_q [1:NUM_REG-1];
  logic [NUM_REG-1:1]       busy_q, busy_d;
  logic [IDX_W:0]           cnt_q, cnt_d;
  logic                     wr_hit, iss_hit;
  logic [IDX_W-1:0]         idx;
  logic [NUM_RD*DATA_W-1:0] rsv_d;
  logic [NUM_RD-1:0]        rsb_d;

  assign wr_hit  = bus.WEn && (bus.rd != '0);
  assign iss_hit = bus.iss_en && (bus.iss_rd != '0);

  // Clear on writeback first, then set on issue: new producer wins.
  always_comb begin
    busy_d = busy_q;
    cnt_d  = '0;
    for (int i = 1; i < NUM_REG; i++) begin
      if (wr_hit && bus.rd == IDX_W'(i))
        busy_d[i] = 1'b0;
      if (iss_hit && bus.iss_rd == IDX_W'(i))
        busy_d[i] = 1'b1;
      cnt_d = cnt_d + (IDX_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 1; i < NUM_REG; i++)
        regs_q[i] <= '0;
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      for (int i = 1; i < NUM_REG; i++)
        if (wr_hit && bus.rd == IDX_W'(i))
          regs_q[i] <= bus.rdv;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    rsv_d = '0;
    rsb_d = '0;
    idx   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      idx = bus.rs[k*IDX_W +: IDX_W];
      for (int i = 1; i < NUM_REG; i++) begin
        if (idx == IDX_W'(i)) begin
          rsv_d[k*DATA_W +: DATA_W] = regs_q[i];
          rsb_d[k] = busy_q[i];
        end
      end
`ifdef REGFILE_BYPASS_EN
      // Forward same-cycle writeback; a colliding issue keeps it busy.
      if (wr_hit && idx == bus.rd) begin
        rsv_d[k*DATA_W +: DATA_W] = bus.rdv;
        rsb_d[k] = iss_hit && (bus.iss_rd == bus.rd);
      end
`endif
    end
    // Keeps forwarded data from leaking out while reset is held.
    if (rst) begin
      rsv_d = '0;
      rsb_d = '0;
    end
  end

  assign bus.rsv      = rsv_d;
  assign bus.rs_busy  = rsb_d;
  assign bus.busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Self-checking bench for regfile_scoreboard (NUM_RD=4).
// Directed table, reset/bypass/multi-port sequences, random vs model.
module tb_regfile_scoreboard;

  localparam int DW = 32;
  localparam int NR = 32;
  localparam int NP = 4;
  localparam int IW = 5;

  logic clk;
  logic rst;

  regfile_scoreboard_if #(
    .DATA_W(DW), .NUM_REG(NR), .NUM_RD(NP), .IDX_W(IW)
  ) bus ();

  regfile_scoreboard #(
    .DATA_W(DW), .NUM_REG(NR), .NUM_RD(NP), .IDX_W(IW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] mregs [NR];
  bit            mbusy [NR];

  typedef struct {
    logic          we;
    logic [IW-1:0] rd;
    logic [DW-1:0] rdv;
    logic          iss;
    logic [IW-1:0] iss_rd;
    logic [IW-1:0] rsel;
    logic [DW-1:0] e_data;
    logic          e_busy;
    logic [IW:0]   e_cnt;
  } vec_t;

  vec_t tbl [10];

  task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      mregs[i] = '0;
      mbusy[i] = 0;
    end
  endfunction

  function automatic int mcount();
    int c = 0;
    for (int i = 1; i < NR; i++) c += int'(mbusy[i]);
    return c;
  endfunction

  function automatic logic [DW-1:0] exp_rsv(int k);
    int idx = int'(bus.rs[k*IW +: IW]);
    if (rst || idx == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (bus.WEn && int'(bus.rd) == idx) return bus.rdv;
`endif
    return mregs[idx];
  endfunction

  function automatic logic exp_busy(int k);
    int idx = int'(bus.rs[k*IW +: IW]);
    if (rst || idx == 0) return 1'b0;
`ifdef REGFILE_BYPASS_EN
    if (bus.WEn && int'(bus.rd) == idx)
      return bus.iss_en && int'(bus.iss_rd) == idx;
`endif
    return mbusy[idx];
  endfunction

  task automatic check_model(string nm);
    for (int k = 0; k < NP; k++) begin
      chk($sformatf("%s rsv%0d", nm, k), bus.rsv[k*DW +: DW], exp_rsv(k));
      chk($sformatf("%s busy%0d", nm, k),
          {31'd0, bus.rs_busy[k]}, {31'd0, exp_busy(k)});
    end
    chk({nm, " cnt"}, {26'd0, bus.busy_cnt}, DW'(mcount()));
  endtask

  task automatic drive(logic we, logic [IW-1:0] rd, logic [DW-1:0] rdv,
                       logic iss, logic [IW-1:0] ird);
    bus.WEn    = we;
    bus.rd     = rd;
    bus.rdv    = rdv;
    bus.iss_en = iss;
    bus.iss_rd = ird;
  endtask

  // Model takes the edge with the inputs the DUT sees, then time moves past it.
  task automatic edge_step();
    if (!rst) begin
      if (bus.WEn && bus.rd != 0) begin
        mregs[bus.rd] = bus.rdv;
        mbusy[bus.rd] = 0;
      end
      if (bus.iss_en && bus.iss_rd != 0)
        mbusy[bus.iss_rd] = 1;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0);
    bus.rs = '0;
    model_clear();

    tbl[0] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd3,  5'd3,  32'h0,        1'b1, 6'd1};
    tbl[1] = '{1'b1, 5'd3, 32'h1234,     1'b0, 5'd0,  5'd3,  32'h1234,     1'b0, 6'd0};
    tbl[2] = '{1'b1, 5'd7, 32'hAA,       1'b1, 5'd7,  5'd7,  32'hAA,       1'b1, 6'd1};
    tbl[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0,  5'd0,  32'h0,        1'b0, 6'd1};
    tbl[4] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0,  5'd0,  32'h0,        1'b0, 6'd1};
    tbl[5] = '{1'b1, 5'd7, 32'hBB,       1'b0, 5'd0,  5'd7,  32'hBB,       1'b0, 6'd0};
    tbl[6] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0,  5'd5,  32'hDEADBEEF, 1'b0, 6'd0};
    tbl[7] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  5'd5,  32'hDEADBEEF, 1'b1, 6'd1};
    tbl[8] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5,  5'd5,  32'hDEADBEEF, 1'b1, 6'd1};
    tbl[9] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd31, 5'd31, 32'h0,        1'b1, 6'd2};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    chk("reset cnt", {26'd0, bus.busy_cnt}, 32'd0);
    chk("reset rsv0", bus.rsv[DW-1:0], 32'd0);

    for (int t = 0; t < 10; t++) begin
      drive(tbl[t].we, tbl[t].rd, tbl[t].rdv, tbl[t].iss, tbl[t].iss_rd);
      edge_step();
      drive(0, 0, 0, 0, 0);
      bus.rs = {15'd0, tbl[t].rsel};
      #2;
      chk($sformatf("tbl%0d data", t), bus.rsv[DW-1:0], tbl[t].e_data);
      chk($sformatf("tbl%0d busy", t), {31'd0, bus.rs_busy[0]},
          {31'd0, tbl[t].e_busy});
      chk($sformatf("tbl%0d cnt", t), {26'd0, bus.busy_cnt},
          {26'd0, tbl[t].e_cnt});
    end

    // Asynchronous reset mid-run: x5 holds DEADBEEF and is busy.
    bus.rs = {5'd7, 5'd3, 5'd31, 5'd5};
    #1;
    rst = 1'b1;
    #1;
    chk("async rst rsv", bus.rsv[127:96] | bus.rsv[95:64] |
        bus.rsv[63:32] | bus.rsv[31:0], 32'd0);
    chk("async rst busy", {28'd0, bus.rs_busy}, 32'd0);
    chk("async rst cnt", {26'd0, bus.busy_cnt}, 32'd0);
    drive(1, 5, 32'h1, 1, 5);
    @(posedge clk);
    #1;
    chk("rst write dropped", bus.rsv[31:0], 32'd0);
    chk("rst issue dropped", {26'd0, bus.busy_cnt}, 32'd0);
    drive(0, 0, 0, 0, 0);
    model_clear();
    rst = 1'b0;
    #2;
    check_model("post rst");

    // Multi-port read of x1..x4, then issue all four.
    for (int i = 1; i <= 4; i++) begin
      drive(1, IW'(i), DW'(i), 0, 0);
      edge_step();
    end
    drive(0, 0, 0, 0, 0);
    bus.rs = {5'd4, 5'd3, 5'd2, 5'd1};
    #2;
    chk("mp rsv hi", bus.rsv[127:64], 64'h00000004_00000003);
    chk("mp rsv lo", bus.rsv[63:0], 64'h00000002_00000001);
    for (int i = 1; i <= 4; i++) begin
      drive(0, 0, 0, 1, IW'(i));
      edge_step();
    end
    drive(0, 0, 0, 0, 0);
    #2;
    chk("mp cnt", {26'd0, bus.busy_cnt}, 32'd4);
    chk("mp busy", {28'd0, bus.rs_busy}, 32'hF);

    // Same-cycle writeback visibility on port 1.
    drive(1, 9, 32'h11, 0, 0);
    edge_step();
    drive(1, 9, 32'h55, 0, 0);
    bus.rs = {5'd0, 5'd0, 5'd9, 5'd0};
    #2;
`ifdef REGFILE_BYPASS_EN
    chk("byp same cycle", bus.rsv[63:32], 32'h55);
`else
    chk("byp same cycle", bus.rsv[63:32], 32'h11);
`endif
    edge_step();
    drive(0, 0, 0, 0, 0);
    #2;
    chk("byp next cycle", bus.rsv[63:32], 32'h55);

    // Random traffic against the model, indices biased to collide.
    for (int n = 0; n < 1500; n++) begin
      logic [IW-1:0] r, ir;
      r  = ($urandom_range(0, 3) == 0) ? IW'($urandom_range(0, 31))
                                       : IW'($urandom_range(0, 7));
      ir = ($urandom_range(0, 3) == 0) ? r : IW'($urandom_range(0, 7));
      drive(1'($urandom_range(0, 1)), r, $urandom,
            1'($urandom_range(0, 1)), ir);
      for (int k = 0; k < NP; k++)
        bus.rs[k*IW +: IW] = ($urandom_range(0, 2) == 0) ? r
                                                         : IW'($urandom_range(0, 7));
      #2;
      check_model($sformatf("rnd%0d", n));
      edge_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised multi-read-port integer register file with a per-register pending-write scoreboard for the pipelined RV32I core. It replaces the single-cycle two-port register bank. It adds configurable read-port count and asynchronous reset of architectural state. It also tracks which registers have an in-flight producer, so the decode stage can detect RAW hazards. An optional write-to-read bypass lets a same-cycle writeback be seen by readers.

## Interface
- `DATA_W`, default 32, register width in bits.
- `NUM_REG`, default 32, number of architectural registers; register 0 is hardwired zero.
- `NUM_RD`, default 2, number of read ports, 1..4.
- `IDX_W`, default $clog2(NUM_REG), register index width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `WEn`  in  1  writeback enable.
- `rd`  in  IDX_W  writeback destination index.
- `rdv`  in  DATA_W  writeback data.
- `iss_en`  in  1  issue strobe: an instruction with a destination leaves decode.
- `iss_rd`  in  IDX_W  destination index of the issuing instruction.
- `rs`  in  NUM_RD*IDX_W  packed read indices; port k uses bits [k*IDX_W +: IDX_W].
- `rsv`  out  NUM_RD*DATA_W  packed read data, same packing.
- `rs_busy`  out  NUM_RD  port k's register has a pending write.
- `busy_cnt`  out  IDX_W+1  number of registers currently marked busy.

## Operation
- Storage: NUM_REG-1 registers of DATA_W bits. Index 0 is not stored. Reads of index 0 return 0 and its busy bit is 0.
- Write: on a rising edge with WEn=1 and rd≠0, regs[rd] ← rdv. Writes to 0 are ignored.
- Read: rsv port k = regs[rs_k], combinational. Index 0 yields 0.
- Scoreboard: one busy bit per register, 1..NUM_REG-1. On each edge, applied in this order:
  - If WEn=1 and rd≠0: clear busy[rd].
  - Then if iss_en=1 and iss_rd≠0: set busy[iss_rd].
- Same-cycle writeback and issue to the same register: busy ends set, because the new producer wins.
- Issue to a register that is already busy: it stays busy. The scoreboard does not count producers, so in-order single-issue is required.
- Writeback to a non-busy register: data is written and busy stays 0. This is not an error.
- rs_busy[k] = busy[rs_k]. It is combinational from current state and does not reflect the same-cycle writeback unless bypass is compiled in.
- busy_cnt is a registered population count of the busy bits, updated on the same edge as the bits. It saturates naturally at NUM_REG-1.
- Reset (rst=1, any time, asynchronous): all registers ← 0, all busy bits ← 0, busy_cnt ← 0. rsv reads 0 for every port and rs_busy = 0 while reset is held. A write or issue coinciding with reset assertion is discarded.

## Timing
- Read latency: 0 cycles (combinational from rs and state).
- Write visibility: written value appears on rsv in the cycle after the edge. With bypass, it appears the same cycle.
- Scoreboard latency: busy set or clear visible on rs_busy and busy_cnt one cycle after the edge.
- Reset release: the first rising edge after rst falls may write and issue.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - When WEn=1, rd≠0 and rs_k==rd, port k returns rdv combinationally and rs_busy[k]=0 in that cycle, unless iss_en=1 and iss_rd==rd.
  - Adds a mux per port.
- `REGFILE_BYPASS_EN` undefined: reads return stored state only. Same-cycle writeback is visible next cycle.

## Test plan
- Reset: assert rst mid-run after writing x5=0xDEADBEEF with x5 busy -> all rsv = 0, rs_busy = 0, busy_cnt = 0 immediately, before any clock edge.
- x0 protection: WEn=1, rd=0, rdv=0xFFFFFFFF, then read rs port0=0 -> rsv=0. Also iss_rd=0 -> busy_cnt unchanged.
- Scoreboard: issue x3 -> next cycle rs_busy=1 for a port reading x3 and busy_cnt=1. Writeback x3=0x1234 -> next cycle rs_busy=0, rsv=0x1234, busy_cnt=0.
- Simultaneous: issue x7 and writeback x7=0xAA on the same edge -> x7 busy=1, rsv=0xAA, busy_cnt=1.
- Bypass: with REGFILE_BYPASS_EN, WEn=1, rd=9, rdv=0x55, rs port1=9 -> rsv port1=0x55 in the same cycle. Without the macro -> old value, then 0x55 next cycle.
- Multi-port: NUM_RD=4, write x1..x4 = 1..4, read rs={4,3,2,1} -> rsv={4,3,2,1}. Issue all four -> busy_cnt=4.
